mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, giving the max consecutive data grants while fetch waits (used only under REQ-024).
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock, all state on rising edge
- Reset  in  1  asynchronous, active-high reset
- IfReq  in  1  fetch stage requests an instruction read
- IfAddr  in  32  fetch address (PC)
- IfInstr  out  32  registered fetched instruction
- IfStall  out  1  fetch must hold
- MemReadM  in  1  MEM-stage load (MemtoRegM)
- MemWriteM  in  1  MEM-stage store
- ALUOutM  in  32  data address
- WriteDataM  in  32  store data
- ReadDataM  out  32  registered load data
- MemStall  out  1  MEM stage and all older stages must hold
- PortReq  out  1  shared memory port request
- PortWe  out  1  port write enable
- PortAddr  out  32  port address
- PortWData  out  32  port write data
- PortRData  in  32  port read data, valid with PortAck
- PortAck  in  1  one-cycle completion pulse from memory

Function
REQ-003 The data request SHALL be DReq = MemReadM | MemWriteM; the fetch request SHALL be IReq = IfReq.
REQ-004 The FSM SHALL have states IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
REQ-005 In IDLE with DReq=1, the FSM SHALL go to BUSY_D; with DReq=0 and IReq=1, to BUSY_I; otherwise it SHALL stay in IDLE.
REQ-006 On a grant, the block SHALL register PortAddr, PortWe and PortWData: ALUOutM/MemWriteM/WriteDataM for data; IfAddr/0/unchanged for fetch.
REQ-007 PortReq SHALL be 1 exactly in BUSY_I and BUSY_D, and port outputs SHALL stay stable until PortAck.
REQ-008 In BUSY_x with PortAck=1, the FSM SHALL go to DONE_x; without it, it SHALL remain in BUSY_x (no timeout).
REQ-009 On the ack cycle in BUSY_I, the block SHALL latch IfInstr <= PortRData.
REQ-010 On the ack cycle in BUSY_D with PortWe=0, the block SHALL latch ReadDataM <= PortRData; for stores ReadDataM SHALL be unchanged.
REQ-011 DONE_I and DONE_D SHALL last exactly one cycle and then return to IDLE.
REQ-012 MemStall SHALL be combinational DReq & (state != DONE_D).
REQ-013 IfStall SHALL be combinational IReq & (state != DONE_I).
REQ-014 Minimum access time SHALL be 3 cycles: grant edge, ack no earlier than the first PortReq cycle, then DONE.
REQ-015 If DReq and IReq are simultaneous in IDLE, data SHALL win unless REQ-024 applies.
REQ-016 PortAck in IDLE or DONE_x SHALL be ignored.
REQ-017 If the requester drops its request during BUSY_x (flush), the access SHALL complete and DONE_x SHALL still be entered, with the result latched but unused.
REQ-018 At most one port access SHALL be outstanding at any time.

Reset
REQ-019 On Reset=1, the block SHALL asynchronously force state=IDLE and PortReq=0 in the same cycle, with no wait for clk.
REQ-020 Reset SHALL zero PortWe, PortAddr, PortWData, IfInstr, ReadDataM and the starvation counter.
REQ-021 Reset during BUSY_x SHALL abandon the access, and any later PortAck for it SHALL be ignored per REQ-016.
REQ-022 While Reset=1, stall outputs SHALL follow REQ-012 and REQ-013 with state=IDLE, so each stall equals its own request.

Configuration
REQ-023 Macro ARB_STARVE_GUARD_EN SHALL select the starvation guard.
REQ-024 With ARB_STARVE_GUARD_EN defined:
- a 3-bit counter SHALL increment on each data grant made while IReq=1, saturating at STARVE_LIMIT
- the counter SHALL clear on any fetch grant
- when count == STARVE_LIMIT and both requests are pending in IDLE, fetch SHALL be granted
REQ-025 Without ARB_STARVE_GUARD_EN, the counter SHALL not exist and data SHALL have strict priority.

Verification
REQ-026 Load: MemReadM=1, ALUOutM=0x40, ack on first PortReq cycle, PortRData=0xDEADBEEF -> PortReq high 1 cycle, ReadDataM=0xDEADBEEF, MemStall low only in DONE_D (3rd cycle).
REQ-027 Store: MemWriteM=1, ALUOutM=0x80, WriteDataM=0x12345678, ack after 3 cycles -> PortWe=1, PortWData=0x12345678 stable 3 cycles, ReadDataM unchanged.
REQ-028 Simultaneous IfReq and MemReadM -> data served first, IfStall high throughout, then fetch granted the cycle after DONE_D->IDLE.
REQ-029 Reset asserted mid-BUSY_D -> PortReq=0 before the next clk edge, and a stray PortAck afterwards leaves ReadDataM=0.
REQ-030 With ARB_STARVE_GUARD_EN and STARVE_LIMIT=4, continuous DReq and IReq -> grant order D,D,D,D,I,D... ; without the macro -> D only.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and the MEM-stage data access.
// Define ARB_STARVE_GUARD_EN to let a waiting fetch win after STARVE_LIMIT back-to-back data grants.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        IfReq,
  input  logic [31:0] IfAddr,
  output logic [31:0] IfInstr,
  output logic        IfStall,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        MemStall,
  output logic        PortReq,
  output logic        PortWe,
  output logic [31:0] PortAddr,
  output logic [31:0] PortWData,
  input  logic [31:0] PortRData,
  input  logic        PortAck
);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D} state_t;

  state_t state, state_next;
  logic   dreq, ireq;
  logic   grant_d, grant_i;
  logic   force_fetch;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_limit
    $error("STARVE_LIMIT must fit the 3-bit starvation counter (1..7)");
  end

  assign dreq = MemReadM | MemWriteM;
  assign ireq = IfReq;

`ifdef ARB_STARVE_GUARD_EN
  logic [2:0] starve_cnt;

  assign force_fetch = (starve_cnt == 3'(STARVE_LIMIT)) & dreq & ireq;

  // Counts data grants that overtook a waiting fetch; any fetch grant resets it.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      starve_cnt <= 3'd0;
    end else if (grant_i) begin
      starve_cnt <= 3'd0;
    end else if (grant_d && ireq && (starve_cnt != 3'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + 3'd1;
    end
  end
`else
  assign force_fetch = 1'b0;
`endif

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant_d    = 1'b0;
    grant_i    = 1'b0;
    case (state)
      IDLE: begin
        if (dreq && !force_fetch) begin
          grant_d    = 1'b1;
          state_next = BUSY_D;
        end else if (ireq) begin
          grant_i    = 1'b1;
          state_next = BUSY_I;
        end
      end
      BUSY_I:  if (PortAck) state_next = DONE_I;
      BUSY_D:  if (PortAck) state_next = DONE_D;
      DONE_I:  state_next = IDLE;
      DONE_D:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Port command is captured at grant time so it stays put however the pipeline moves.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      PortWe    <= 1'b0;
      PortAddr  <= 32'd0;
      PortWData <= 32'd0;
      IfInstr   <= 32'd0;
      ReadDataM <= 32'd0;
    end else begin
      if (grant_d) begin
        PortAddr  <= ALUOutM;
        PortWe    <= MemWriteM;
        PortWData <= WriteDataM;
      end else if (grant_i) begin
        PortAddr  <= IfAddr;
        PortWe    <= 1'b0;
      end
      if (state == BUSY_I && PortAck) IfInstr <= PortRData;
      if (state == BUSY_D && PortAck && !PortWe) ReadDataM <= PortRData;
    end
  end

  assign PortReq  = (state == BUSY_I) || (state == BUSY_D);
  assign MemStall = dreq & (state != DONE_D);
  assign IfStall  = ireq & (state != DONE_I);

endmodule
